// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - renderer and video-out signal bundle for vga_scan_gen
interface vga_scan_gen_if;
  logic        hit;
  logic [5:0]  luma;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [5:0]  rgb;

  // Scan generator side: issues counts and video, consumes renderer results
  modport master (
    input  hit, luma,
    output h_count, v_count, frame_start, frame_count, hsync, vsync, de, rgb
  );

  // Renderer / display side
  modport slave (
    output hit, luma,
    input  h_count, v_count, frame_start, frame_count, hsync, vsync, de, rgb
  );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA timing counters, latency-matched syncs and rgb output stage
module vga_scan_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIX_DIV    = 1,
  parameter int RENDER_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_gen_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]    div;
  logic                tick;
  logic                h_wrap;
  logic                v_wrap;
  logic [10:0]         h_count;
  logic [9:0]          v_count;
  logic [15:0]         frame_count;
  logic                raw_hsync;
  logic                raw_vsync;
  logic                raw_de;
  logic [RENDER_LAT:0] hsync_sr;
  logic [RENDER_LAT:0] vsync_sr;
  logic [RENDER_LAT:0] de_sr;
  logic [5:0]          rgb;

  assign tick   = (div == DIV_LAST);
  assign h_wrap = tick && (h_count == H_LAST);
  assign v_wrap = h_wrap && (v_count == V_LAST);

  // Raw timing decoded from the counts currently issued to the renderer
  assign raw_hsync = !((h_count >= HS_BEG) && (h_count < HS_END));
  assign raw_vsync = !((v_count >= VS_BEG) && (v_count < VS_END));
  assign raw_de    = (h_count < H_VIS) && (v_count < V_VIS);

  // Clock divider producing one pixel tick every PIX_DIV clocks
  always_ff @(posedge clk) begin
    if (rst || tick) div <= '0;
    else             div <= div + DIV_W'(1);
  end

  // Pixel and line counters, advancing only on pixel ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 11'd1;
      end
    end
  end

  // Frame counter bumps on the edge that wraps the counts back to (0,0)
  always_ff @(posedge clk) begin
    if (rst)         frame_count <= '0;
    else if (v_wrap) frame_count <= frame_count + 16'd1;
  end

  // Sync/enable delay lines so they line up with the renderer's answer
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_sr <= '1;
      vsync_sr <= '1;
      de_sr    <= '0;
    end else begin
      hsync_sr <= {hsync_sr[RENDER_LAT-1:0], raw_hsync};
      vsync_sr <= {vsync_sr[RENDER_LAT-1:0], raw_vsync};
      de_sr    <= {de_sr[RENDER_LAT-1:0], raw_de};
    end
  end

  // Colour stage: blank outside the visible area, luma-based grey on hit, else background
  always_ff @(posedge clk) begin
    if (rst)                     rgb <= '0;
    else if (!de_sr[RENDER_LAT-1]) rgb <= '0;
    else if (bus.hit)            rgb <= {3{bus.luma[5:4]}};
    else                         rgb <= 6'b000001;
  end

  // A reset on the wrap edge suppresses the pulse since the counts clear anyway
  assign bus.frame_start = v_wrap && !rst;
  assign bus.h_count     = h_count;
  assign bus.v_count     = v_count;
  assign bus.frame_count = frame_count;
  assign bus.hsync       = hsync_sr[RENDER_LAT];
  assign bus.vsync       = vsync_sr[RENDER_LAT];
  assign bus.de          = de_sr[RENDER_LAT];
  assign bus.rgb         = rgb;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen
module tb_vga_scan_gen;
  localparam int PD [3]  = '{1, 3, 1};
  localparam int LAT [3] = '{4, 4, 2};
  localparam int HD [3]  = '{640, 640, 8};
  localparam int HF [3]  = '{16, 16, 2};
  localparam int HS [3]  = '{96, 96, 3};
  localparam int HB [3]  = '{48, 48, 2};
  localparam int VD [3]  = '{480, 480, 4};
  localparam int VF [3]  = '{10, 10, 1};
  localparam int VS [3]  = '{2, 2, 2};
  localparam int VB [3]  = '{33, 33, 1};

  typedef struct {
    int          n;
    logic        hit;
    logic [5:0]  luma;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        de;
    logic [5:0]  rgb;
  } vec_t;

  logic        clk;
  logic        rst_d [3];
  logic        hit_d [3];
  logic [5:0]  luma_d [3];
  logic [46:0] act [3];
  int          n [3];
  bit          model_on [3];
  int          n_chk;
  int          n_pass;
  vec_t        tbl [12];
  int          ti;

  vga_scan_gen_if bus_a ();
  vga_scan_gen_if bus_b ();
  vga_scan_gen_if bus_c ();

  vga_scan_gen u_a (.clk(clk), .rst(rst_d[0]), .bus(bus_a));
  vga_scan_gen #(.PIX_DIV(3)) u_b (.clk(clk), .rst(rst_d[1]), .bus(bus_b));
  vga_scan_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIX_DIV(1), .RENDER_LAT(2)
  ) u_c (.clk(clk), .rst(rst_d[2]), .bus(bus_c));

  assign bus_a.hit = hit_d[0];
  assign bus_a.luma = luma_d[0];
  assign bus_b.hit = hit_d[1];
  assign bus_b.luma = luma_d[1];
  assign bus_c.hit = hit_d[2];
  assign bus_c.luma = luma_d[2];

  assign act[0] = {bus_a.h_count, bus_a.v_count, bus_a.frame_start, bus_a.frame_count,
                   bus_a.hsync, bus_a.vsync, bus_a.de, bus_a.rgb};
  assign act[1] = {bus_b.h_count, bus_b.v_count, bus_b.frame_start, bus_b.frame_count,
                   bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.rgb};
  assign act[2] = {bus_c.h_count, bus_c.v_count, bus_c.frame_start, bus_c.frame_count,
                   bus_c.hsync, bus_c.vsync, bus_c.de, bus_c.rgb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: everything follows from the number of clocks elapsed since reset release
  function automatic logic [46:0] exp_vec(input int d, input int nn, input logic rst_now,
                                          input logic hit, input logic [5:0] luma);
    int ht, vt, per, pix, h, v, m, mh, mv;
    logic fs, hs, vs, de;
    logic [5:0] rgb;
    ht  = HD[d] + HF[d] + HS[d] + HB[d];
    vt  = VD[d] + VF[d] + VS[d] + VB[d];
    per = PD[d] * ht * vt;
    pix = nn / PD[d];
    h   = pix % ht;
    v   = (pix / ht) % vt;
    fs  = !rst_now && (((nn + 1) % per) == 0);
    hs  = 1'b1;
    vs  = 1'b1;
    de  = 1'b0;
    rgb = 6'd0;
    m   = nn - (LAT[d] + 1);
    if (m >= 0) begin
      mh  = (m / PD[d]) % ht;
      mv  = ((m / PD[d]) / ht) % vt;
      hs  = !(mh >= HD[d] + HF[d] && mh < HD[d] + HF[d] + HS[d]);
      vs  = !(mv >= VD[d] + VF[d] && mv < VD[d] + VF[d] + VS[d]);
      de  = (mh < HD[d]) && (mv < VD[d]);
      rgb = !de ? 6'd0 : (hit ? {luma[5:4], luma[5:4], luma[5:4]} : 6'd1);
    end
    return {11'(h), 10'(v), fs, 16'(nn / per), hs, vs, de, rgb};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask

  // One clock: inputs are already driven; advance model on the edge, compare at negedge
  task automatic step();
    logic [46:0] ev;
    @(posedge clk);
    for (int d = 0; d < 3; d++) n[d] = rst_d[d] ? 0 : n[d] + 1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (model_on[d]) begin
        ev = exp_vec(d, n[d], rst_d[d], hit_d[d], luma_d[d]);
        chk(act[d] === ev, $sformatf("model_%0d n=%0d", d, n[d]), 64'(act[d]), 64'(ev));
      end
    end
  endtask

  task automatic tbl_check();
    if (ti < 12 && tbl[ti].n == n[0]) begin
      chk(bus_a.h_count === tbl[ti].h, $sformatf("tbl%0d h", ti), 64'(bus_a.h_count), 64'(tbl[ti].h));
      chk(bus_a.v_count === tbl[ti].v, $sformatf("tbl%0d v", ti), 64'(bus_a.v_count), 64'(tbl[ti].v));
      chk(bus_a.hsync === tbl[ti].hs, $sformatf("tbl%0d hsync", ti), 64'(bus_a.hsync), 64'(tbl[ti].hs));
      chk(bus_a.de === tbl[ti].de, $sformatf("tbl%0d de", ti), 64'(bus_a.de), 64'(tbl[ti].de));
      chk(bus_a.rgb === tbl[ti].rgb, $sformatf("tbl%0d rgb", ti), 64'(bus_a.rgb), 64'(tbl[ti].rgb));
      ti++;
    end
  endtask

  initial begin
    bit a_rst_done;
    int hs_low, c_vs_low, c_de_hi, c_fs, rst_left, guard;
    n_chk = 0;
    n_pass = 0;
    ti = 0;
    a_rst_done = 0;
    hs_low = 0;
    c_vs_low = 0;
    c_de_hi = 0;
    c_fs = 0;
    rst_left = 0;
    //            n    hit   luma   h       v      hs    de    rgb
    tbl[0]  = '{0,   1'b1, 6'h3F, 11'd0,   10'd0, 1'b1, 1'b0, 6'h00};
    tbl[1]  = '{4,   1'b1, 6'h3F, 11'd4,   10'd0, 1'b1, 1'b0, 6'h00};
    tbl[2]  = '{5,   1'b1, 6'h2C, 11'd5,   10'd0, 1'b1, 1'b1, 6'h2A};
    tbl[3]  = '{6,   1'b0, 6'h3F, 11'd6,   10'd0, 1'b1, 1'b1, 6'h01};
    tbl[4]  = '{644, 1'b1, 6'h30, 11'd644, 10'd0, 1'b1, 1'b1, 6'h3F};
    tbl[5]  = '{645, 1'b1, 6'h3F, 11'd645, 10'd0, 1'b1, 1'b0, 6'h00};
    tbl[6]  = '{660, 1'b0, 6'h00, 11'd660, 10'd0, 1'b1, 1'b0, 6'h00};
    tbl[7]  = '{661, 1'b1, 6'h3F, 11'd661, 10'd0, 1'b0, 1'b0, 6'h00};
    tbl[8]  = '{756, 1'b1, 6'h3F, 11'd756, 10'd0, 1'b0, 1'b0, 6'h00};
    tbl[9]  = '{757, 1'b1, 6'h3F, 11'd757, 10'd0, 1'b1, 1'b0, 6'h00};
    tbl[10] = '{800, 1'b1, 6'h3F, 11'd0,   10'd1, 1'b1, 1'b0, 6'h00};
    tbl[11] = '{805, 1'b1, 6'h1F, 11'd5,   10'd1, 1'b1, 1'b1, 6'h15};

    for (int d = 0; d < 3; d++) begin
      rst_d[d] = 1'b1;
      hit_d[d] = 1'b0;
      luma_d[d] = 6'd0;
      n[d] = 0;
      model_on[d] = 1'b1;
    end
    for (int i = 0; i < 3; i++) step();
    for (int d = 0; d < 3; d++) rst_d[d] = 1'b0;
    tbl_check();

    for (int cyc = 0; cyc < 2600; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        hit_d[d] = 1'($urandom_range(0, 1));
        luma_d[d] = 6'($urandom);
      end
      if (!a_rst_done && ti < 12 && tbl[ti].n == n[0] + 1) begin
        hit_d[0] = tbl[ti].hit;
        luma_d[0] = tbl[ti].luma;
      end
      if (!a_rst_done && n[0] == 1100) begin
        chk(bus_a.h_count == 11'd300 && bus_a.v_count == 10'd1, "pre_reset_pos",
            64'({bus_a.h_count, bus_a.v_count}), 64'({11'd300, 10'd1}));
        rst_d[0] = 1'b1;
      end else begin
        rst_d[0] = 1'b0;
      end
      if (cyc > 300) begin
        if (rst_left > 0) begin
          rst_d[2] = 1'b1;
          rst_left--;
        end else begin
          rst_d[2] = 1'b0;
          if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
        end
      end

      step();

      if (rst_d[0]) begin
        chk(bus_a.h_count == 11'd0 && bus_a.v_count == 10'd0, "midline_reset_counts",
            64'({bus_a.h_count, bus_a.v_count}), 64'd0);
        chk(bus_a.frame_start == 1'b0, "midline_reset_no_pulse", 64'(bus_a.frame_start), 64'd0);
        a_rst_done = 1;
      end
      if (!a_rst_done) begin
        tbl_check();
        if (n[0] >= 5 && n[0] < 805 && bus_a.hsync == 1'b0) hs_low++;
      end
      case (n[1])
        4, 5:  chk(bus_b.h_count == 11'd1, $sformatf("b_hold n=%0d", n[1]), 64'(bus_b.h_count), 64'd1);
        6:     chk(bus_b.h_count == 11'd2, "b_step", 64'(bus_b.h_count), 64'd2);
        1972:  chk(bus_b.hsync == 1'b1, "b_hsync_pre", 64'(bus_b.hsync), 64'd1);
        1973:  chk(bus_b.hsync == 1'b0, "b_hsync_start", 64'(bus_b.hsync), 64'd0);
        2399:  chk(bus_b.h_count == 11'd799 && bus_b.v_count == 10'd0, "b_line_end",
                   64'({bus_b.h_count, bus_b.v_count}), 64'({11'd799, 10'd0}));
        2400:  chk(bus_b.h_count == 11'd0 && bus_b.v_count == 10'd1, "b_line_wrap",
                   64'({bus_b.h_count, bus_b.v_count}), 64'({11'd0, 10'd1}));
        default: ;
      endcase
      if (cyc < 300) begin
        if (n[2] >= 3 && n[2] < 123) begin
          if (bus_c.vsync == 1'b0) c_vs_low++;
          if (bus_c.de == 1'b1) c_de_hi++;
        end
        if (n[2] < 120 && bus_c.frame_start == 1'b1) c_fs++;
        if (n[2] == 120) chk(bus_c.frame_count == 16'd1, "c_frame_count", 64'(bus_c.frame_count), 64'd1);
      end
    end

    chk(hs_low == 96, "a_hsync_low_width", 64'(hs_low), 64'd96);
    chk(c_vs_low == 30, "c_vsync_low_clocks", 64'(c_vs_low), 64'd30);
    chk(c_de_hi == 32, "c_de_high_clocks", 64'(c_de_hi), 64'd32);
    chk(c_fs == 1, "c_frame_start_pulses", 64'(c_fs), 64'd1);

    // frame_count rollover: preload 0xFFFF and let the next frame wrap it
    model_on[2] = 1'b0;
    rst_d[2] = 1'b0;
    force u_c.frame_count = 16'hFFFF;
    step();
    guard = 0;
    while (bus_c.frame_start !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    chk(bus_c.frame_start === 1'b1, "wrap_pulse_seen", 64'(bus_c.frame_start), 64'd1);
    release u_c.frame_count;
    chk(bus_c.frame_count == 16'hFFFF, "wrap_preload", 64'(bus_c.frame_count), 64'hFFFF);
    step();
    chk(bus_c.frame_count == 16'h0000, "wrap_to_zero", 64'(bus_c.frame_count), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
